// File: rtl/issue_rr_arbiter_pkg.sv
// Shared issue-path definitions: default port count and the issue payload
// type that issue_rr_arbiter is normally instantiated with.
package issue_rr_arbiter_pkg;

    localparam int ISSUE_PORTS = 4;

    typedef struct packed {
        logic [5:0]  rob_tag;
        logic [31:0] result;
    } issue_pkt_t;

endpackage

// File: rtl/issue_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping,
// found with a double-width masked priority encode.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Low half keeps only requests at or above ptr; high half is the wrapped copy.
    logic [2*N_REQ-1:0] dbl_req;
    logic               found;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign dbl_req[gi]         = req[gi] && (gi >= int'(ptr));
            assign dbl_req[gi + N_REQ] = req[gi];
        end
    endgenerate

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        for (int j = 0; j < 2 * N_REQ; j++) begin
            if (!found && dbl_req[j]) begin
                found = 1'b1;
                if (j < N_REQ) begin
                    gnt_onehot[j] = 1'b1;
                    gnt_idx       = IDX_W'(j);
                end else begin
                    gnt_onehot[j - N_REQ] = 1'b1;
                    gnt_idx               = IDX_W'(j - N_REQ);
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/issue_rr_arbiter.sv
// Round-robin arbiter funnelling N_REQ valid/ready producers into one
// registered output stage with one-cycle latency and full throughput.
module issue_rr_arbiter
    import issue_rr_arbiter_pkg::*;
#(
    parameter type T     = logic,
    parameter int  N_REQ = ISSUE_PORTS,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [N_REQ-1:0] valid_in,
    output logic [N_REQ-1:0] ready_in,
    input  T                 data_in [N_REQ],
    output logic             valid_out,
    input  logic             ready_out,
    output T                 data_out,
    output logic [IDX_W-1:0] grant_id_out
);

    logic             out_valid_reg;
    T                 out_data_reg;
    logic [IDX_W-1:0] out_id_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] rr_ptr_next;

    logic [N_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0] gnt_idx;
    logic             any_req;
    logic             can_load;
    logic             load;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (valid_in),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    assign can_load = !out_valid_reg || ready_out;
    // Gated by reset so no producer sees a grant while the stage is held clear.
    assign load     = reset && can_load && any_req && !flush;
    assign ready_in = load ? gnt_onehot : '0;

    assign rr_ptr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_in[gnt_idx];
            out_id_reg    <= gnt_idx;
            rr_ptr_reg    <= rr_ptr_next;
        end else if (ready_out) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign valid_out    = out_valid_reg;
    assign data_out     = out_data_reg;
    assign grant_id_out = out_id_reg;

endmodule

// File: tb/tb_issue_rr_arbiter.sv
// Directed self-checking bench for issue_rr_arbiter: a 4-port instance for the
// main scenarios and a 3-port instance for the non-power-of-2 wrap case.
module tb_issue_rr_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-requester instance
    logic       flush_a = 1'b0;
    logic [3:0] valid_a = '0;
    logic [3:0] ready_in_a;
    logic [7:0] data_a [4];
    logic       valid_out_a;
    logic       ready_out_a = 1'b0;
    logic [7:0] data_out_a;
    logic [1:0] id_a;

    // 3-requester instance
    logic       flush_b = 1'b0;
    logic [2:0] valid_b = '0;
    logic [2:0] ready_in_b;
    logic [7:0] data_b [3];
    logic       valid_out_b;
    logic       ready_out_b = 1'b0;
    logic [7:0] data_out_b;
    logic [1:0] id_b;

    issue_rr_arbiter #(.T(logic [7:0]), .N_REQ(4)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a),
        .valid_in(valid_a), .ready_in(ready_in_a), .data_in(data_a),
        .valid_out(valid_out_a), .ready_out(ready_out_a),
        .data_out(data_out_a), .grant_id_out(id_a)
    );

    issue_rr_arbiter #(.T(logic [7:0]), .N_REQ(3)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b),
        .valid_in(valid_b), .ready_in(ready_in_b), .data_in(data_b),
        .valid_out(valid_out_b), .ready_out(ready_out_b),
        .data_out(data_out_b), .grant_id_out(id_b)
    );

    task automatic test_reset;
        for (int i = 0; i < 4; i++) data_a[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 3; i++) data_b[i] = 8'h20 + 8'(i);
        reset = 1'b0;
        valid_a = 4'hF;
        ready_out_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %0b expected 0", valid_out_a); end
        checks++; if (ready_in_a !== 4'b0000) begin errors++; $display("FAIL reset_ready_in: got %b expected 0000", ready_in_a); end
        checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out_a); end
        checks++; if (id_a !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", id_a); end
        reset = 1'b1;
        #1;
        checks++; if (ready_in_a !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b expected 0001", ready_in_a); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            $display("rr cycle %0d: valid_out=%0b grant_id=%0d data=%h", k, valid_out_a, id_a, data_out_a);
            checks++; if (valid_out_a !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b expected 1", k, valid_out_a); end
            checks++; if (id_a !== 2'(k % 4)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, id_a, k % 4); end
            checks++; if (data_out_a !== 8'h10 + 8'(k % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, data_out_a, 8'h10 + 8'(k % 4)); end
        end
    endtask

    // Entered with rr_ptr=1 and the output register busy but draining.
    task automatic test_single;
        valid_a = 4'b0100;
        data_a[2] = 8'hA5;
        #1;
        checks++; if (ready_in_a !== 4'b0100) begin errors++; $display("FAIL single_ready_in: got %b expected 0100", ready_in_a); end
        @(negedge clk);
        $display("single: valid_out=%0b grant_id=%0d data=%h", valid_out_a, id_a, data_out_a);
        checks++; if (valid_out_a !== 1'b1 || data_out_a !== 8'hA5 || id_a !== 2'd2) begin errors++; $display("FAIL single_out: got v=%0b d=%h id=%0d expected v=1 d=a5 id=2", valid_out_a, data_out_a, id_a); end
        valid_a = 4'b1010;
        #1;
        checks++; if (ready_in_a !== 4'b1000) begin errors++; $display("FAIL ptr_after_single: got %b expected 1000", ready_in_a); end
        @(negedge clk);
        $display("after single: grant_id=%0d data=%h", id_a, data_out_a);
        checks++; if (id_a !== 2'd3 || data_out_a !== 8'h13) begin errors++; $display("FAIL req3_out: got id=%0d d=%h expected id=3 d=13", id_a, data_out_a); end
    endtask

    task automatic test_backpressure;
        valid_a = 4'b0011;
        ready_out_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ready_in_a !== 4'b0000) begin errors++; $display("FAIL stall_ready_in[%0d]: got %b expected 0000", k, ready_in_a); end
            @(negedge clk);
            $display("stall %0d: valid_out=%0b grant_id=%0d data=%h", k, valid_out_a, id_a, data_out_a);
            checks++; if (valid_out_a !== 1'b1 || id_a !== 2'd3 || data_out_a !== 8'h13) begin errors++; $display("FAIL stall_hold[%0d]: got v=%0b id=%0d d=%h expected v=1 id=3 d=13", k, valid_out_a, id_a, data_out_a); end
        end
        ready_out_a = 1'b1;
        #1;
        checks++; if (ready_in_a !== 4'b0001) begin errors++; $display("FAIL drain_reload_ready: got %b expected 0001", ready_in_a); end
        @(negedge clk);
        $display("drain+reload: valid_out=%0b grant_id=%0d data=%h", valid_out_a, id_a, data_out_a);
        checks++; if (valid_out_a !== 1'b1 || id_a !== 2'd0 || data_out_a !== 8'h10) begin errors++; $display("FAIL drain_reload_out: got v=%0b id=%0d d=%h expected v=1 id=0 d=10", valid_out_a, id_a, data_out_a); end
    endtask

    // rr_ptr is 1 on entry; after the flush requesters 0 and 1 both ask, so 1 must win.
    task automatic test_flush;
        ready_out_a = 1'b0;
        valid_a = 4'b0010;
        flush_a = 1'b1;
        #1;
        checks++; if (ready_in_a !== 4'b0000) begin errors++; $display("FAIL flush_ready_in: got %b expected 0000", ready_in_a); end
        @(negedge clk);
        $display("flush: valid_out=%0b", valid_out_a);
        checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL flush_valid_out: got %0b expected 0", valid_out_a); end
        flush_a = 1'b0;
        ready_out_a = 1'b1;
        valid_a = 4'b0011;
        #1;
        checks++; if (ready_in_a !== 4'b0010) begin errors++; $display("FAIL flush_ptr_kept: got %b expected 0010", ready_in_a); end
        @(negedge clk);
        $display("after flush: valid_out=%0b grant_id=%0d data=%h", valid_out_a, id_a, data_out_a);
        checks++; if (valid_out_a !== 1'b1 || id_a !== 2'd1 || data_out_a !== 8'h11) begin errors++; $display("FAIL after_flush_out: got v=%0b id=%0d d=%h expected v=1 id=1 d=11", valid_out_a, id_a, data_out_a); end
    endtask

    task automatic test_async_reset;
        ready_out_a = 1'b0;
        valid_a = 4'b1100;
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: valid_out=%0b ready_in=%b", valid_out_a, ready_in_a);
        checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL async_valid_out: got %0b expected 0", valid_out_a); end
        checks++; if (ready_in_a !== 4'b0000) begin errors++; $display("FAIL async_ready_in: got %b expected 0000", ready_in_a); end
        @(negedge clk);
        reset = 1'b1;
        ready_out_a = 1'b1;
        #1;
        checks++; if (ready_in_a !== 4'b0100) begin errors++; $display("FAIL post_reset_grant: got %b expected 0100", ready_in_a); end
        @(negedge clk);
        $display("post reset: valid_out=%0b grant_id=%0d data=%h", valid_out_a, id_a, data_out_a);
        checks++; if (valid_out_a !== 1'b1 || id_a !== 2'd2 || data_out_a !== 8'hA5) begin errors++; $display("FAIL post_reset_out: got v=%0b id=%0d d=%h expected v=1 id=2 d=a5", valid_out_a, id_a, data_out_a); end
        valid_a = '0;
    endtask

    task automatic test_wrap;
        ready_out_b = 1'b1;
        valid_b = 3'b010;
        @(negedge clk);
        checks++; if (id_b !== 2'd1 || valid_out_b !== 1'b1) begin errors++; $display("FAIL wrap_setup: got v=%0b id=%0d expected v=1 id=1", valid_out_b, id_b); end
        valid_b = 3'b101;
        #1;
        checks++; if (ready_in_b !== 3'b100) begin errors++; $display("FAIL wrap_ready_2: got %b expected 100", ready_in_b); end
        @(negedge clk);
        $display("wrap: grant_id=%0d data=%h", id_b, data_out_b);
        checks++; if (id_b !== 2'd2 || data_out_b !== 8'h22) begin errors++; $display("FAIL wrap_out_2: got id=%0d d=%h expected id=2 d=22", id_b, data_out_b); end
        #1;
        checks++; if (ready_in_b !== 3'b001) begin errors++; $display("FAIL wrap_ready_0: got %b expected 001", ready_in_b); end
        @(negedge clk);
        $display("wrap: grant_id=%0d data=%h", id_b, data_out_b);
        checks++; if (id_b !== 2'd0 || data_out_b !== 8'h20) begin errors++; $display("FAIL wrap_out_0: got id=%0d d=%h expected id=0 d=20", id_b, data_out_b); end
        valid_b = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_rr_arbiter.md
Name: issue_rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream valid/ready channel between N_REQ upstream producers. Typical use: issue queues competing for one execution/writeback port.
- Each input is a valid/ready/data channel carrying a generic payload type T.
- Single registered output stage, 1-cycle latency, full throughput of one transfer per cycle.
- Sits between the producer skid stages and the consumer pipeline register.

Parameters:
- T, logic, payload type carried on every channel.
- N_REQ, 4, number of requesters; legal range 2..16, need not be a power of 2.
- IDX_W, $clog2(N_REQ), width of requester index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- flush  input  1  synchronous kill of the in-flight output entry (pipeline flush).
- valid_in  input  N_REQ  per-requester valid.
- ready_in  output  N_REQ  per-requester ready; at most one bit set per cycle.
- data_in  input  N_REQ x T  per-requester payload (unpacked array of T).
- valid_out  output  1  output entry valid.
- ready_out  input  1  consumer accepts the output entry.
- data_out  output  T  registered payload of the granted requester.
- grant_id_out  output  IDX_W  index of the requester whose payload is in data_out.

Behaviour:
- State:
  - out_valid, out_data, out_id (output register).
  - rr_ptr[IDX_W-1:0] (highest-priority requester index).
- Reset (reset==0, asynchronous):
  - out_valid=0, out_data=0, out_id=0, rr_ptr=0.
  - valid_out=0, data_out=0, grant_id_out=0, ready_in=all 0.
- Stage ready: can_load = !out_valid || ready_out. Combinational on ready_out; this is accepted.
- Pick (combinational):
  - Winner w = first i with valid_in[i], scanning rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ... rr_ptr-1 (mod N_REQ).
  - any_req = |valid_in.
- Grant: ready_in[w] = can_load && any_req && !flush. All other bits are 0.
- ready_in must not depend on valid_in of the granted requester's own channel beyond the pick. Producers must not drop valid once asserted until transferred.
- Load (posedge, valid_in[w] && ready_in[w]):
  - out_data <= data_in[w], out_id <= w, out_valid <= 1.
  - rr_ptr <= (w==N_REQ-1) ? 0 : w+1.
- Drain without load: out_valid && ready_out and no load gives out_valid <= 0. out_data and out_id hold their values.
- Simultaneous drain and load in the same cycle: new entry replaces the old one. No bubble, 1 transfer/cycle.
- Stall: out_valid && !ready_out gives ready_in=0, and out_data, out_id and rr_ptr hold.
- Flush (flush==1 at posedge):
  - out_valid <= 0; no load that cycle (ready_in forced 0); rr_ptr unchanged.
  - Flush overrides simultaneous drain.
- No requests: rr_ptr holds, and out_valid follows the drain rule.
- Latency: input handshake at edge k gives valid_out=1 from edge k to edge k+1 onward, i.e. visible in cycle k+1.
- Fairness: with all inputs continuously valid and ready_out=1, grant order is rr_ptr, rr_ptr+1, ... A requester waits at most N_REQ-1 grants.
- Reset mid-operation: an in-flight entry is discarded immediately (asynchronous). rr_ptr returns to 0.

Decomposition:
- Shared package (core_pkg): keep ISSUE_PORTS (default for N_REQ) there.
- The payload struct types (e.g. issue_pkt_t) already in that package are passed as T.
- No new typedefs are needed.
- One sub-module: rr_pick (combinational).
  - Inputs: req[N_REQ], ptr[IDX_W].
  - Outputs: gnt_onehot[N_REQ], gnt_idx[IDX_W], any.
  - Implemented as a double-width masked priority encode, reusable by other arbiters.

Test Plan:
- Reset with all valid_in=1, then release reset, ready_out=1.
  - valid_out=0 and ready_in=0 while reset==0.
  - First grant is to requester 0.
  - grant_id_out sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Only requester 2 valid (data 0xA5), ready_out=1.
  - ready_in=4'b0100.
  - Next cycle valid_out=1, data_out=0xA5, grant_id_out=2.
  - rr_ptr=3, and if requesters 1 and 3 are then valid, 3 wins.
- Backpressure: output valid, ready_out=0 for 3 cycles with requesters 0 and 1 valid.
  - ready_in=0 throughout, and data_out and grant_id_out stable.
  - On ready_out=1, drain and reload occur in the same cycle.
- Flush asserted while valid_out=1 and ready_out=0 with requester 1 valid.
  - Next cycle valid_out=0, and requester 1 is not granted during the flush cycle.
  - rr_ptr is unchanged.
- N_REQ=3, rr_ptr=2, requesters 0 and 2 valid.
  - Requester 2 granted, rr_ptr wraps to 0.
  - Then requester 0 granted.
- Asynchronous reset pulse mid-cycle while valid_out=1.
  - valid_out=0 immediately, without waiting for a clock edge.
  - After release, the first grant goes to the lowest-index valid requester.
